// File: rtl/map_pkg.sv
// Shared constants and encodings for the level-map collision checker.
// Also intended for use by the renderer.
package map_pkg;

  localparam int TILE_LOG2 = 5;
  localparam int MAP_COLS  = 15;
  localparam int MAP_ROWS  = 10;
  localparam int MAP_BITS  = MAP_COLS * MAP_ROWS;
  localparam int TILE_PX   = 1 << TILE_LOG2;

  localparam logic [10:0] MAX_X    = 11'(MAP_COLS * TILE_PX - 1);
  localparam logic [10:0] MAX_Y    = 11'(MAP_ROWS * TILE_PX - 1);
  localparam logic [10:0] EDGE_OFF = 11'(TILE_PX - 1);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_CHK_A,
    ST_CHK_B,
    ST_DONE
  } state_e;

endpackage

// File: rtl/map_tile_lookup.sv
// Combinational wall-bit lookup: tile (row,col) lives at bit 149-(row*15+col).
// Out-of-range tiles read as free.
module map_tile_lookup
  import map_pkg::*;
(
  input  logic [MAP_BITS-1:0] mapBits_i,
  input  logic [3:0]          col_i,
  input  logic [3:0]          row_i,
  output logic                wall_o
);

  logic [7:0] linIdx;
  logic [7:0] bitPos;

  // row*15 is formed as (row<<4)-row so no multiplier is needed
  always_comb begin
    linIdx = ({4'd0, row_i} << 4) - {4'd0, row_i} + {4'd0, col_i};
    bitPos = 8'(MAP_BITS - 1) - linIdx;
    wall_o = 1'b0;
    if (linIdx < 8'(MAP_BITS)) begin
      wall_o = mapBits_i[bitPos];
    end
  end

endmodule

// File: rtl/map_collision.sv
// Move-legality checker: tests the two leading-edge sprite corners after a step
// against a shadow copy of the level map, answering via a req/ack handshake.
module map_collision
  import map_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [MAP_BITS-1:0] map_in,
  input  logic                map_load,
  input  logic                req,
  input  logic [9:0]          xpos,
  input  logic [9:0]          ypos,
  input  logic [1:0]          dir,
  input  logic [3:0]          step,
  output logic                ready,
  output logic                ack,
  output logic                blocked
);

  state_e state_q, state_d;

  logic [9:0]  x_q, y_q;
  dir_e        dir_q;
  logic [3:0]  step_q;
  logic [10:0] cornerAx_d, cornerAy_d, cornerBx_d, cornerBy_d;
  logic        oob_d, oob_q;
  logic [3:0]  colA_q, rowA_q, colB_q, rowB_q;
  logic        hitA_q, hitB_q, ack_q, blocked_q;
  logic [MAP_BITS-1:0] shadow_q, staging_q;
  logic        loadPending_q;
  logic        accept;
  logic [3:0]  lookupCol, lookupRow;
  logic        lookupWall;

  assign accept = (state_q == ST_IDLE) && req;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req) state_d = ST_CALC;
      ST_CALC:  state_d = ST_CHK_A;
      ST_CHK_A: state_d = ST_CHK_B;
      ST_CHK_B: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready   = (state_q == ST_IDLE);
    ack     = ack_q;
    blocked = blocked_q;
  end

  // Corner geometry in 11 bits so the +31 edge offset never wraps
  always_comb begin
    logic [10:0] xExt, yExt, stepExt;
    logic        under;
    xExt       = {1'b0, x_q};
    yExt       = {1'b0, y_q};
    stepExt    = {7'd0, step_q};
    under      = 1'b0;
    cornerAx_d = xExt;
    cornerAy_d = yExt;
    cornerBx_d = xExt + EDGE_OFF;
    cornerBy_d = yExt;
    case (dir_q)
      DIR_UP: begin
        under      = yExt < stepExt;
        cornerAy_d = yExt - stepExt;
        cornerBy_d = yExt - stepExt;
      end
      DIR_DOWN: begin
        cornerAy_d = yExt + stepExt + EDGE_OFF;
        cornerBy_d = yExt + stepExt + EDGE_OFF;
      end
      DIR_LEFT: begin
        under      = xExt < stepExt;
        cornerAx_d = xExt - stepExt;
        cornerBx_d = xExt - stepExt;
        cornerBy_d = yExt + EDGE_OFF;
      end
      default: begin
        cornerAx_d = xExt + stepExt + EDGE_OFF;
        cornerBx_d = xExt + stepExt + EDGE_OFF;
        cornerBy_d = yExt + EDGE_OFF;
      end
    endcase
    oob_d = under || (cornerAx_d > MAX_X) || (cornerBx_d > MAX_X) ||
            (cornerAy_d > MAX_Y) || (cornerBy_d > MAX_Y);
  end

  assign lookupCol = (state_q == ST_CHK_B) ? colB_q : colA_q;
  assign lookupRow = (state_q == ST_CHK_B) ? rowB_q : rowA_q;

  map_tile_lookup u_lookup (
    .mapBits_i (shadow_q),
    .col_i     (lookupCol),
    .row_i     (lookupRow),
    .wall_o    (lookupWall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      dir_q     <= DIR_UP;
      step_q    <= '0;
      oob_q     <= 1'b0;
      colA_q    <= '0;
      rowA_q    <= '0;
      colB_q    <= '0;
      rowB_q    <= '0;
      hitA_q    <= 1'b0;
      hitB_q    <= 1'b0;
      ack_q     <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      ack_q <= (state_q == ST_DONE);
      if (accept) begin
        x_q    <= xpos;
        y_q    <= ypos;
        dir_q  <= dir_e'(dir);
        step_q <= step;
      end
      if (state_q == ST_CALC) begin
        oob_q  <= oob_d;
        colA_q <= cornerAx_d[TILE_LOG2 +: 4];
        rowA_q <= cornerAy_d[TILE_LOG2 +: 4];
        colB_q <= cornerBx_d[TILE_LOG2 +: 4];
        rowB_q <= cornerBy_d[TILE_LOG2 +: 4];
      end
      if (state_q == ST_CHK_A) hitA_q <= !oob_q && lookupWall;
      if (state_q == ST_CHK_B) hitB_q <= !oob_q && lookupWall;
      if (state_q == ST_DONE)  blocked_q <= oob_q | hitA_q | hitB_q;
    end
  end

  // Loads arriving mid-query are staged so each query sees one consistent map
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q      <= '0;
      staging_q     <= '0;
      loadPending_q <= 1'b0;
    end else if (map_load && (state_q == ST_IDLE) && !req) begin
      shadow_q <= map_in;
    end else if (map_load && (state_q == ST_DONE)) begin
      shadow_q      <= map_in;
      loadPending_q <= 1'b0;
    end else if (map_load) begin
      staging_q     <= map_in;
      loadPending_q <= 1'b1;
    end else if ((state_q == ST_DONE) && loadPending_q) begin
      shadow_q      <= staging_q;
      loadPending_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_map_collision.sv
// Scoreboard bench for map_collision: expected results are queued when a
// query is issued and compared when ack fires.
module tb_map_collision;

  logic         clk;
  logic         rst;
  logic [149:0] map_in;
  logic         map_load;
  logic         req;
  logic [9:0]   xpos, ypos;
  logic [1:0]   dir;
  logic [3:0]   step;
  logic         ready, ack, blocked;

  int checkCount   = 0;
  int failCount    = 0;
  int ackCount     = 0;
  int expectedAcks = 0;
  logic expQ[$];
  logic [149:0] modelMap;

  map_collision dut (
    .clk      (clk),
    .rst      (rst),
    .map_in   (map_in),
    .map_load (map_load),
    .req      (req),
    .xpos     (xpos),
    .ypos     (ypos),
    .dir      (dir),
    .step     (step),
    .ready    (ready),
    .ack      (ack),
    .blocked  (blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic tileAt(input logic [149:0] m, input int col, input int row);
    return m[149 - (row * 15 + col)];
  endfunction

  function automatic logic [149:0] withTile(input logic [149:0] m, input int row, input int col);
    logic [149:0] r;
    r = m;
    r[149 - (row * 15 + col)] = 1'b1;
    return r;
  endfunction

  // Reference model in plain signed integer geometry
  function automatic logic expBlocked(input logic [149:0] m, input int x, input int y,
                                      input int d, input int s);
    int ax, ay, bx, by;
    case (d)
      0: begin ax = x;          ay = y - s;      bx = x + 31; by = y - s;      end
      1: begin ax = x;          ay = y + s + 31; bx = x + 31; by = y + s + 31; end
      2: begin ax = x - s;      ay = y;          bx = x - s;  by = y + 31;     end
      default: begin ax = x + s + 31; ay = y;    bx = ax;     by = y + 31;     end
    endcase
    if (ax < 0 || ay < 0 || ax > 479 || bx > 479 || ay > 319 || by > 319) return 1'b1;
    return tileAt(m, ax / 32, ay / 32) | tileAt(m, bx / 32, by / 32);
  endfunction

  always @(negedge clk) begin
    if (ack === 1'b1) begin
      ackCount++;
      if (expQ.size() == 0) checkOutput("queriesOutstanding", expQ.size(), 1);
      else checkOutput("blocked", blocked, expQ.pop_front());
    end
  end

  task automatic loadMap(input logic [149:0] m);
    @(negedge clk);
    map_in   = m;
    map_load = 1'b1;
    @(negedge clk);
    map_load = 1'b0;
    modelMap = m;
  endtask

  task automatic applyStimulus(input int x, input int y, input int d, input int s,
                               input bit holdReq, input int loadAt,
                               input logic [149:0] loadData);
    logic expVal;
    bit   got;
    int   lat;
    @(negedge clk);
    xpos = 10'(x);
    ypos = 10'(y);
    dir  = 2'(d);
    step = 4'(s);
    req  = 1'b1;
    expVal = expBlocked(modelMap, x, y, d, s);
    expQ.push_back(expVal);
    expectedAcks++;
    got = 1'b0;
    lat = 0;
    for (int cyc = 1; cyc <= 12 && !got; cyc++) begin
      @(negedge clk);
      if (cyc == 1) checkOutput("readyBusy", ready, 0);
      if (!holdReq || cyc >= 3) req = 1'b0;
      if (cyc == loadAt) begin
        map_in   = loadData;
        map_load = 1'b1;
      end else begin
        map_load = 1'b0;
      end
      if (ack === 1'b1) begin
        got = 1'b1;
        lat = cyc;
      end
    end
    req      = 1'b0;
    map_load = 1'b0;
    checkOutput("ackLatency", lat, 5);
    if (!got) begin
      expQ.delete(expQ.size() - 1);
      expectedAcks--;
    end else begin
      @(negedge clk);
      checkOutput("readyAfterAck", ready, 1);
      checkOutput("ackPulse", ack, 0);
      checkOutput("blockedHeld", blocked, expVal);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [149:0] m;
    rst      = 1'b1;
    req      = 1'b0;
    map_load = 1'b0;
    map_in   = '0;
    xpos     = '0;
    ypos     = '0;
    dir      = '0;
    step     = '0;
    modelMap = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetReady", ready, 1);
    checkOutput("resetAck", ack, 0);
    checkOutput("resetBlocked", blocked, 0);
    rst = 1'b0;

    $display("[TB] basic free move");
    applyStimulus(32, 32, 3, 4, 1'b0, -1, '0);

    $display("[TB] single wall at (1,3)");
    loadMap(withTile('0, 1, 3));
    applyStimulus(64, 32, 3, 1, 1'b0, -1, '0);
    applyStimulus(64, 32, 3, 0, 1'b0, -1, '0);

    $display("[TB] map edges");
    loadMap('0);
    applyStimulus(2, 0, 2, 3, 1'b0, -1, '0);
    applyStimulus(448, 0, 3, 1, 1'b0, -1, '0);
    applyStimulus(447, 0, 3, 1, 1'b0, -1, '0);
    applyStimulus(0, 0, 0, 0, 1'b0, -1, '0);
    applyStimulus(0, 288, 1, 1, 1'b0, -1, '0);

    $display("[TB] half-tile straddle");
    loadMap(withTile('0, 2, 0));
    applyStimulus(16, 32, 0, 2, 1'b0, -1, '0);
    applyStimulus(48, 96, 1, 1, 1'b0, -1, '0);
    loadMap(withTile('0, 4, 2));
    applyStimulus(48, 96, 1, 1, 1'b0, -1, '0);

    $display("[TB] load during query");
    applyStimulus(32, 32, 3, 4, 1'b0, 2, '1);
    modelMap = '1;
    applyStimulus(32, 32, 3, 4, 1'b0, -1, '0);

    $display("[TB] reset during query");
    @(negedge clk);
    xpos = 10'd32; ypos = 10'd32; dir = 2'd3; step = 4'd4;
    req  = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelMap = '0;
    checkOutput("abortReady", ready, 1);
    checkOutput("abortBlocked", blocked, 0);
    checkOutput("abortAck", ack, 0);
    repeat (8) @(negedge clk);
    applyStimulus(32, 32, 3, 4, 1'b0, -1, '0);

    $display("[TB] request held while busy");
    loadMap(withTile('0, 1, 2));
    applyStimulus(32, 32, 3, 4, 1'b1, -1, '0);
    repeat (8) @(negedge clk);

    $display("[TB] random queries");
    m = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    loadMap(m);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(int'($urandom_range(0, 470)), int'($urandom_range(0, 310)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                    1'b0, -1, '0);
    end

    repeat (4) @(negedge clk);
    checkOutput("ackCount", ackCount, expectedAcks);
    checkOutput("queueDrained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/map_collision.md
Name: map_collision

Overview:
- Consumer of the 150-bit level map: 15 columns x 10 rows, 1 bit per tile, 1 = wall.
- Holds a shadow copy of the current level map.
- Answers move-legality queries from the player/enemy movement logic through a req/ack handshake.
- Evaluates the two leading-edge corners of a square sprite after a proposed step. Returns blocked/free a fixed number of cycles later.

Parameters:
- TILE_LOG2, 5, tile edge = 2**TILE_LOG2 px (32); sprite edge equals tile edge.
- MAP_COLS, 15, tiles per row.
- MAP_ROWS, 10, tile rows.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- map_in  in  150  level map; bit index 149-(row*15+col) holds tile (row,col), MSB = row0 col0.
- map_load  in  1  pulse: capture map_in into shadow.
- req  in  1  query request; accepted only when ready=1.
- xpos  in  10  sprite top-left x, map-relative px.
- ypos  in  10  sprite top-left y, map-relative px.
- dir  in  2  0=up, 1=down, 2=left, 3=right.
- step  in  4  proposed move in px (0..15).
- ready  out  1  high in IDLE.
- ack  out  1  one-cycle pulse, result valid.
- blocked  out  1  result; held until next ack.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values: ready=1, ack=0, blocked=0, shadow map all 0, load_pending=0, FSM=IDLE. Reset mid-query aborts it; no ack is issued.
- FSM states: IDLE -> CALC -> CHK_A -> CHK_B -> DONE -> IDLE.
  - IDLE: ready=1. On req, register xpos/ypos/dir/step. ready drops the next cycle.
  - CALC: compute the new position in 11-bit unsigned arithmetic, then the two corner pixels:
    - up: y'=y-step; corners (x,y') and (x+31,y').
    - down: y'=y+step; corners (x,y'+31) and (x+31,y'+31).
    - left: x'=x-step; corners (x',y) and (x',y+31).
    - right: x'=x+step; corners (x'+31,y) and (x'+31,y+31).
  - Out-of-map flag, set in CALC: underflow (y<step for up, x<step for left), or any corner x>479 or y>319 (MAP_COLS*32-1, MAP_ROWS*32-1).
  - CHK_A: tile col = cx>>TILE_LOG2, row = cy>>TILE_LOG2. Look up the shadow bit and latch it in hitA.
  - CHK_B: same lookup for corner B, latched in hitB.
  - DONE: blocked <= oob | hitA | hitB; ack=1 for exactly this cycle. Return to IDLE.
- Latency: req sampled at edge N gives ack high during the cycle after edge N+4. Throughput is one query per 5 cycles.
- req while ready=0 is ignored and not queued.
- No bit lookup happens when oob is set; the result is blocked=1 regardless of shadow contents.
- step=0: both corners lie inside the current footprint; the result is a plain overlap test.
- map_load:
  - In IDLE with no query starting: shadow <= map_in next edge.
  - While busy, or coincident with an accepted req: set load_pending and latch map_in into a staging register. The shadow updates on the DONE->IDLE transition, so a query always sees one consistent map.
  - A second load while pending overwrites the staging register.
- Index arithmetic: the linear index row*15+col is computed as (row<<4)-row+col in 8 bits. No divider.

Decomposition:
- Shared package map_pkg: MAP_COLS, MAP_ROWS, MAP_BITS=150, TILE_LOG2, direction encodings DIR_UP/DOWN/LEFT/RIGHT, FSM state encodings.
- One sub-module, map_tile_lookup: purely combinational (map, col, row) -> wall bit with the MSB-first index rule. It is reusable by the renderer.

Test Plan:
- Reset, then an all-zero map, req at x=32,y=32,dir=right,step=4 -> ack exactly 5 cycles after req, blocked=0, ready returns 1 the cycle after ack.
- Load a map with only tile (1,3) set (bit 149-18=131). req x=64,y=32,dir=right,step=1 -> corner x=96 is col 3 -> blocked=1. Same query with step=0 -> blocked=0.
- Underflow: x=2,y=0,dir=left,step=3 -> blocked=1. x=448,y=0,dir=right,step=1 -> corner x=480 -> blocked=1. x=447,dir=right,step=1 -> blocked=0 with an empty map.
- Half-tile straddle: wall at (2,0) only. x=16,y=32,dir=up,step=2 -> corner A (16,30) is tile (0,0), free; corner B (47,30) is tile (0,1), free -> blocked=0. x=48,y=96,dir=down,step=1 -> corner B (79,128) is tile (4,2) -> blocked=0. Moving wall to (4,2) -> blocked=1.
- map_load asserted in CHK_A with a map of all ones: the in-flight query returns the old-map result; the next query returns blocked=1.
- rst asserted during CHK_B -> no ack, ready=1 and blocked=0 next cycle, shadow cleared. req during busy produces no extra ack.
